// File: rtl/grah8_cond_pkg.sv
// Shared types for the Grah-8 condition/branch logic: condition codes,
// flag bit positions and the branch-unit state encoding.
package grah8_cond_pkg;

  localparam int FLAG_W = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [3:0] {
    COND_NEVER  = 4'd0,
    COND_ALWAYS = 4'd1,
    COND_EQ     = 4'd2,
    COND_NE     = 4'd3,
    COND_CS     = 4'd4,
    COND_CC     = 4'd5,
    COND_MI     = 4'd6,
    COND_PL     = 4'd7,
    COND_VS     = 4'd8,
    COND_VC     = 4'd9,
    COND_HI     = 4'd10,
    COND_LS     = 4'd11,
    COND_GE     = 4'd12,
    COND_LT     = 4'd13,
    COND_GT     = 4'd14,
    COND_LE     = 4'd15
  } cond_code_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    OFFER = 2'd2
  } state_e;

endpackage

// File: rtl/cond_eval_lut.sv
// Combinational condition evaluator: maps a 4-bit condition code and the
// {N,V,C,Z} flags to a single branch-taken result. Also used by decode.
import grah8_cond_pkg::*;

module cond_eval_lut (
  input  logic [FLAG_W-1:0] flags,
  input  logic [3:0]        cond_code,
  output logic              result
);

  logic n, v, c, z;

  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];
  assign z = flags[FLAG_Z];

  always_comb begin
    result = 1'b0;
    case (cond_code_e'(cond_code))
      COND_NEVER:  result = 1'b0;
      COND_ALWAYS: result = 1'b1;
      COND_EQ:     result = z;
      COND_NE:     result = !z;
      COND_CS:     result = c;
      COND_CC:     result = !c;
      COND_MI:     result = n;
      COND_PL:     result = !n;
      COND_VS:     result = v;
      COND_VC:     result = !v;
      COND_HI:     result = c && !z;
      COND_LS:     result = !c || z;
      COND_GE:     result = (n == v);
      COND_LT:     result = (n != v);
      COND_GT:     result = !z && (n == v);
      COND_LE:     result = z || (n != v);
      default:     result = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// Flags register, condition evaluation and taken-branch offer to fetch.
// Optional interrupt flag shadow register: define COND_UNIT_SHADOW_EN.
//
// state | meaning
// IDLE  | eval_ready=1, waiting for a branch request
// EVAL  | request captured, condition evaluated against flags_q
// OFFER | taken branch presented to fetch until br_ready
import grah8_cond_pkg::*;

module cond_branch_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef COND_UNIT_SHADOW_EN
  input  logic              shadow_save,
  input  logic              shadow_restore,
`endif
  input  logic              flag_we,
  input  logic [FLAG_W-1:0] flag_in,
  output logic [FLAG_W-1:0] flags_out,
  input  logic              eval_valid,
  output logic              eval_ready,
  input  logic [3:0]        cond_code,
  input  logic [ADDR_W-1:0] target,
  output logic              resolve,
  output logic              taken,
  output logic              br_valid,
  output logic [ADDR_W-1:0] br_target,
  input  logic              br_ready
);

  state_e              state;
  logic [FLAG_W-1:0]   flags_q;
  logic [3:0]          cond_q;
  logic [ADDR_W-1:0]   target_q;
  logic                cond_result;

  assign flags_out = flags_q;

`ifdef COND_UNIT_SHADOW_EN
  logic [FLAG_W-1:0] shadow_q;

  // Save and restore in the same cycle swap, since both read pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q  <= '0;
      shadow_q <= '0;
    end else begin
      if (flag_we)             flags_q <= flag_in;
      else if (shadow_restore) flags_q <= shadow_q;
      if (shadow_save)         shadow_q <= flags_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         flags_q <= '0;
    else if (flag_we) flags_q <= flag_in;
  end
`endif

  cond_eval_lut u_cond_eval_lut (
    .flags     (flags_q),
    .cond_code (cond_q),
    .result    (cond_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      eval_ready <= 1'b1;
      resolve    <= 1'b0;
      taken      <= 1'b0;
      br_valid   <= 1'b0;
      br_target  <= '0;
      cond_q     <= '0;
      target_q   <= '0;
    end else begin
      resolve <= 1'b0;
      taken   <= 1'b0;
      case (state)
        IDLE: begin
          if (eval_valid) begin
            cond_q     <= cond_code;
            target_q   <= target;
            eval_ready <= 1'b0;
            state      <= EVAL;
          end
        end
        EVAL: begin
          resolve <= 1'b1;
          taken   <= cond_result;
          if (cond_result) begin
            br_valid  <= 1'b1;
            br_target <= target_q;
            state     <= OFFER;
          end else begin
            eval_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        OFFER: begin
          if (br_ready) begin
            br_valid   <= 1'b0;
            eval_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          br_valid   <= 1'b0;
          eval_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Self-checking bench for cond_branch_unit: directed condition table,
// full code/flag sweep, and hand sequences for handshake/reset corners.
module tb_cond_branch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_we;
  logic [3:0] flag_in;
  logic [3:0] flags_out;
  logic       eval_valid;
  logic       eval_ready;
  logic [3:0] cond_code;
  logic [7:0] target;
  logic       resolve;
  logic       taken;
  logic       br_valid;
  logic [7:0] br_target;
  logic       br_ready;
`ifdef COND_UNIT_SHADOW_EN
  logic       shadow_save;
  logic       shadow_restore;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_branch_unit #(.ADDR_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef COND_UNIT_SHADOW_EN
    .shadow_save    (shadow_save),
    .shadow_restore (shadow_restore),
`endif
    .flag_we        (flag_we),
    .flag_in        (flag_in),
    .flags_out      (flags_out),
    .eval_valid     (eval_valid),
    .eval_ready     (eval_ready),
    .cond_code      (cond_code),
    .target         (target),
    .resolve        (resolve),
    .taken          (taken),
    .br_valid       (br_valid),
    .br_target      (br_target),
    .br_ready       (br_ready)
  );

  typedef struct {
    logic [3:0] fl;
    logic [3:0] cc;
    logic       exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference condition table written from {N,V,C,Z} semantics.
  function automatic logic model(input logic [3:0] f, input logic [3:0] cc);
    logic n, v, c, z;
    {n, v, c, z} = f;
    case (cc)
      4'd0:  return 1'b0;
      4'd1:  return 1'b1;
      4'd2:  return z;
      4'd3:  return ~z;
      4'd4:  return c;
      4'd5:  return ~c;
      4'd6:  return n;
      4'd7:  return ~n;
      4'd8:  return v;
      4'd9:  return ~v;
      4'd10: return c & ~z;
      4'd11: return ~c | z;
      4'd12: return ~(n ^ v);
      4'd13: return n ^ v;
      4'd14: return ~z & ~(n ^ v);
      default: return z | (n ^ v);
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (eval_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("eval_ready_wait", {31'd0, eval_ready}, 32'd1);
  endtask

  task automatic run_branch(input logic [3:0] fl, input logic [3:0] cc,
                            input logic [7:0] tgt, input logic exp, input string nm);
    wait_ready();
    flag_we = 1'b1; flag_in = fl;
    tick();
    flag_we = 1'b0;
    eval_valid = 1'b1; cond_code = cc; target = tgt; br_ready = 1'b1;
    tick();
    eval_valid = 1'b0;
    check({nm, "_busy"}, {31'd0, eval_ready}, 32'd0);
    check({nm, "_resolve0"}, {31'd0, resolve}, 32'd0);
    tick();
    check({nm, "_resolve"}, {31'd0, resolve}, 32'd1);
    check({nm, "_taken"}, {31'd0, taken}, {31'd0, exp});
    check({nm, "_br_valid"}, {31'd0, br_valid}, {31'd0, exp});
    check({nm, "_ready_e1"}, {31'd0, eval_ready}, {31'd0, ~exp});
    if (exp) check({nm, "_br_target"}, {24'd0, br_target}, {24'd0, tgt});
    tick();
    check({nm, "_resolve_drop"}, {31'd0, resolve}, 32'd0);
    check({nm, "_br_valid_done"}, {31'd0, br_valid}, 32'd0);
    check({nm, "_ready_done"}, {31'd0, eval_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 4'd0,  1'b0};
    vecs[1]  = '{4'b0000, 4'd1,  1'b1};
    vecs[2]  = '{4'b0001, 4'd2,  1'b1};
    vecs[3]  = '{4'b0000, 4'd3,  1'b1};
    vecs[4]  = '{4'b0010, 4'd4,  1'b1};
    vecs[5]  = '{4'b0010, 4'd5,  1'b0};
    vecs[6]  = '{4'b1000, 4'd6,  1'b1};
    vecs[7]  = '{4'b1000, 4'd7,  1'b0};
    vecs[8]  = '{4'b0100, 4'd8,  1'b1};
    vecs[9]  = '{4'b0100, 4'd9,  1'b0};
    vecs[10] = '{4'b0010, 4'd10, 1'b1};
    vecs[11] = '{4'b0011, 4'd10, 1'b0};
    vecs[12] = '{4'b0011, 4'd11, 1'b1};
    vecs[13] = '{4'b1100, 4'd12, 1'b1};
    vecs[14] = '{4'b1000, 4'd13, 1'b1};
    vecs[15] = '{4'b0001, 4'd14, 1'b0};
    vecs[16] = '{4'b0000, 4'd14, 1'b1};
    vecs[17] = '{4'b0100, 4'd15, 1'b1};

    rst = 1'b0; flag_we = 1'b0; flag_in = '0; eval_valid = 1'b0;
    cond_code = '0; target = '0; br_ready = 1'b0;
`ifdef COND_UNIT_SHADOW_EN
    shadow_save = 1'b0; shadow_restore = 1'b0;
`endif
    #12;
    check("rst_eval_ready", {31'd0, eval_ready}, 32'd1);
    check("rst_flags", {28'd0, flags_out}, 32'd0);
    check("rst_br_valid", {31'd0, br_valid}, 32'd0);
    check("rst_br_target", {24'd0, br_target}, 32'd0);
    check("rst_resolve", {31'd0, resolve}, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 18; i++)
      run_branch(vecs[i].fl, vecs[i].cc, 8'h10 + 8'(i), vecs[i].exp, $sformatf("vec%0d", i));

    run_branch(4'b0001, 4'd2, 8'h3C, 1'b1, "eq_taken");
    run_branch(4'b0000, 4'd2, 8'h3C, 1'b0, "eq_not_taken");

    // Flag write at accept edge is seen; write during EVAL is not.
    wait_ready();
    flag_we = 1'b1; flag_in = 4'b1000;
    eval_valid = 1'b1; cond_code = 4'd13; target = 8'h77; br_ready = 1'b1;
    tick();
    eval_valid = 1'b0; flag_we = 1'b1; flag_in = 4'b0000;
    tick();
    flag_we = 1'b0;
    check("vis_resolve", {31'd0, resolve}, 32'd1);
    check("vis_taken", {31'd0, taken}, 32'd1);
    check("vis_flags_after", {28'd0, flags_out}, 32'd0);
    tick();
    check("vis_ready", {31'd0, eval_ready}, 32'd1);

    // Fetch stall: offer must hold steady and new requests are ignored.
    flag_we = 1'b1; flag_in = 4'b0000;
    tick();
    flag_we = 1'b0;
    eval_valid = 1'b1; cond_code = 4'd1; target = 8'hA5; br_ready = 1'b0;
    tick();
    cond_code = 4'd0; target = 8'h5A;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_br_valid", {31'd0, br_valid}, 32'd1);
      check("stall_br_target", {24'd0, br_target}, 32'hA5);
      check("stall_eval_ready", {31'd0, eval_ready}, 32'd0);
      tick();
    end
    br_ready = 1'b1; eval_valid = 1'b0;
    tick();
    check("stall_br_valid_done", {31'd0, br_valid}, 32'd0);
    check("stall_ready_done", {31'd0, eval_ready}, 32'd1);

    // Full sweep against the reference table.
    for (int f = 0; f < 16; f++)
      for (int cc = 0; cc < 16; cc++) begin
        wait_ready();
        flag_we = 1'b1; flag_in = 4'(f);
        tick();
        flag_we = 1'b0;
        eval_valid = 1'b1; cond_code = 4'(cc); br_ready = 1'b1;
        tick();
        eval_valid = 1'b0;
        tick();
        if (taken !== model(4'(f), 4'(cc)) || resolve !== 1'b1) begin
          errors++;
          $display("FAIL sweep f=%0h cc=%0d: taken=%b resolve=%b expected taken=%b",
                   f, cc, taken, resolve, model(4'(f), 4'(cc)));
        end
        checks++;
        tick();
      end

    // Asynchronous reset in the middle of an offer.
    wait_ready();
    flag_we = 1'b1; flag_in = 4'b0001;
    tick();
    flag_we = 1'b0;
    eval_valid = 1'b1; cond_code = 4'd2; target = 8'hC3; br_ready = 1'b0;
    tick();
    eval_valid = 1'b0;
    tick();
    check("mid_br_valid", {31'd0, br_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_br_valid", {31'd0, br_valid}, 32'd0);
    check("mid_rst_resolve", {31'd0, resolve}, 32'd0);
    check("mid_rst_flags", {28'd0, flags_out}, 32'd0);
    check("mid_rst_br_target", {24'd0, br_target}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, eval_ready}, 32'd1);
    check("post_rst_br_valid", {31'd0, br_valid}, 32'd0);

`ifdef COND_UNIT_SHADOW_EN
    flag_we = 1'b1; flag_in = 4'b1010;
    tick();
    flag_we = 1'b0; shadow_save = 1'b1;
    tick();
    shadow_save = 1'b0; flag_we = 1'b1; flag_in = 4'b0101;
    tick();
    flag_we = 1'b0;
    check("shadow_written", {28'd0, flags_out}, 32'h5);
    shadow_restore = 1'b1;
    tick();
    shadow_restore = 1'b0;
    check("shadow_restore", {28'd0, flags_out}, 32'hA);
    shadow_restore = 1'b1; flag_we = 1'b1; flag_in = 4'b0011;
    tick();
    shadow_restore = 1'b0; flag_we = 1'b0;
    check("shadow_we_priority", {28'd0, flags_out}, 32'h3);
    shadow_save = 1'b1; shadow_restore = 1'b1;
    tick();
    shadow_save = 1'b0; shadow_restore = 1'b0;
    check("shadow_swap_flags", {28'd0, flags_out}, 32'hA);
    shadow_restore = 1'b1;
    tick();
    shadow_restore = 1'b0;
    check("shadow_swap_shadow", {28'd0, flags_out}, 32'h3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cond_branch_unit.md
Name: cond_branch_unit

Overview:
- Flags register plus condition evaluator and branch-request stage for the Grah-8 CPU.
- Latches ALU flags (N,V,C,Z). Accepts a branch request carrying a 4-bit condition code and an 8-bit target, and evaluates the condition against the latched flags.
- Taken branches are offered to the fetch stage over a valid/ready handshake.
- Sits directly upstream of the decode-side AND gating, which consumes the taken and resolve signals.

Parameters:
- ADDR_W, 8, width of branch target/PC.
- FLAG_W, 4, flag vector width {N,V,C,Z}, MSB to LSB; fixed at 4, not meant to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-low.
- flag_we  in  1  load flag_in into the flags register.
- flag_in  in  4  ALU flags {N,V,C,Z}.
- flags_out  out  4  current flags register.
- eval_valid  in  1  branch request present.
- eval_ready  out  1  unit can accept a request.
- cond_code  in  4  condition code, sampled on accept.
- target  in  ADDR_W  branch target, sampled on accept.
- resolve  out  1  one-cycle pulse when the evaluation completes.
- taken  out  1  condition result; meaningful while resolve=1.
- br_valid  out  1  taken-branch request to fetch.
- br_target  out  ADDR_W  target for fetch; held stable while br_valid=1.
- br_ready  in  1  fetch accepts br_target.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - all outputs 0, except eval_ready=1 (state IDLE);
  - flags_out=0, br_target=0.
  - Reset mid-handshake drops br_valid immediately; the pending branch is lost.
- Flags register:
  - Loads flag_in on the rising edge when flag_we=1, in any state.
  - flags_out is the register output, no bypass.
- FSM states and transitions:
  - IDLE: eval_ready=1. On eval_valid=1, accept: capture cond_code and target, go to EVAL.
  - EVAL: eval_ready=0. Compute cond(flags_q). Next edge: resolve=1 for one cycle and taken=result, both registered. If taken, go to OFFER with br_valid=1; else go to IDLE.
  - OFFER: br_valid=1, eval_ready=0. When br_ready=1 at an edge, go to IDLE and clear br_valid.
- Latency:
  - Accept at edge E0; evaluation at edge E1.
  - resolve and br_valid are visible in the cycle after E1.
  - Minimum turnaround for a taken branch with br_ready held high: 3 cycles from accept to the next eval_ready=1. Not-taken: 2 cycles.
- Flag visibility:
  - A flag_we coincident with the accept edge is visible to that evaluation, because the register updates at E0.
  - A flag_we during EVAL is not visible to that evaluation; it applies to later ones.
- While busy, eval_valid is ignored. The requester must hold the request until eval_ready=1.
- br_ready may already be high when br_valid first asserts; the handoff then takes one cycle in OFFER.
- br_ready while not in OFFER is ignored.
- Condition codes:
  - 0 NEVER, 1 ALWAYS
  - 2 EQ Z, 3 NE !Z
  - 4 CS C, 5 CC !C
  - 6 MI N, 7 PL !N
  - 8 VS V, 9 VC !V
  - 10 HI C&!Z, 11 LS !C|Z
  - 12 GE N==V, 13 LT N!=V
  - 14 GT !Z&(N==V), 15 LE Z|(N!=V)

Optional Feature:
- Macro: COND_UNIT_SHADOW_EN.
- With the macro defined:
  - Adds input ports shadow_save and shadow_restore (1 bit each) and a 4-bit shadow register, reset to 0, used for interrupt entry/exit.
  - shadow_save=1: shadow <= flags_q.
  - shadow_restore=1: flags <= shadow.
  - Both at once: swap.
  - flag_we has priority over shadow_restore for the flags register.
- Without the macro: no ports, no shadow register.

Decomposition:
- Package grah8_cond_pkg holds:
  - cond_code enum (the 16 codes above);
  - flag bit index constants FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_N=3;
  - FSM state enum {IDLE, EVAL, OFFER}.
- One combinational sub-module cond_eval_lut (inputs flags, cond_code; output result), reused by decode.

Test Plan:
- Reset with rst=0 mid-OFFER (br_valid=1) -> br_valid, resolve and flags_out go to 0 immediately; eval_ready=1 after release.
- flag_in=4'b0001 (Z) with flag_we, then request cond=2 (EQ), target=8'h3C -> resolve=1, taken=1; br_valid=1 with br_target=8'h3C; br_ready held high clears it in one cycle.
- flags=0, request cond=2 -> resolve=1, taken=0; br_valid stays 0; eval_ready=1 two cycles after accept.
- flag_we in the accept cycle with flag_in=4'b1000, cond=13 (LT) -> taken=1. flag_we during EVAL with flag_in=4'b0000 -> still taken=1; flags_out=0 afterwards.
- Taken branch with br_ready low for 5 cycles -> br_valid and br_target stable; eval_valid ignored (eval_ready=0); completes when br_ready rises.
- Sweep all 16 cond codes across all 16 flag values -> taken matches the table. With COND_UNIT_SHADOW_EN: save 4'b1010, write 4'b0101, restore -> flags_out=4'b1010.
